l1a_rdout_sched: RTL and testbench
==================================

Name: l1a_rdout_sched

Overview:
- Event readout scheduler downstream of the trigger-control L1A/LCT match logic.
- Queues each L1A together with its per-channel L1A-match mask and an event number.
- Sequences readout of the matched channels' data FIFOs one at a time, lowest index first, using a req/done handshake.
- Brackets each event with start/end strobes for the DAQ formatter.

Parameters:
- NCH, 6, number of readout channels (ALCT + 5 CFEBs); index 0 = ALCT.
- QDEPTH, 8, event-descriptor queue depth; power of 2, 2..64.
- TMO_BITS, 10, width of the per-channel done-timeout counter.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- L1A  in  1  single-cycle L1A strobe (pushed-L1A timing).
- L1A_MATCH  in  NCH  per-channel match mask; valid in the L1A cycle.
- CH_EN  in  NCH  static channel enable mask (config); sampled with L1A.
- CH_DONE  in  NCH  per-channel single-cycle "channel readout complete".
- OVF_CLR  in  1  clears the sticky overflow flag.
- RD_REQ  out  NCH  one-hot read request, held until done or timeout.
- EVT_START  out  1  one-cycle pulse at event begin.
- EVT_END  out  1  one-cycle pulse at event end.
- EVT_NUM  out  12  event number of the event in service; valid from EVT_START through EVT_END.
- EVT_MASK  out  NCH  effective mask of the event in service.
- EVT_TMO  out  NCH  channels that timed out in the current event; valid with EVT_END.
- Q_FULL  out  1  descriptor queue full.
- Q_OVF  out  1  sticky: an L1A was dropped.
- BUSY  out  1  FSM not IDLE, or queue not empty.

Behaviour:
- Reset (async, RST_N=0):
  - All outputs 0; queue emptied; event counter = 0; FSM = IDLE.
  - RD_REQ drops immediately, without waiting for a clock edge.
  - An in-flight event is abandoned; no EVT_END is issued.
- Event counter (12 bit, wraps 4095 -> 0):
  - Increments on every L1A, including dropped ones, so drops show as gaps in EVT_NUM.
- Queue write on L1A:
  - Writes descriptor {evt_cnt, L1A_MATCH & CH_EN}.
  - If full and no pop in the same cycle: descriptor dropped, Q_OVF set.
  - Simultaneous push and pop while full: accepted; occupancy unchanged.
- Q_OVF: held until an OVF_CLR cycle. OVF_CLR coincident with a new drop leaves it set.
- FSM states: IDLE, HDR, REQ, TRL.
  - IDLE: when the queue is non-empty, go to HDR. Pop the head into EVT_NUM/EVT_MASK and a working copy rem_mask. Clear EVT_TMO.
  - HDR (1 cycle): EVT_START=1. If rem_mask=0, go to TRL; else go to REQ on ch = lowest set bit of rem_mask.
  - REQ: RD_REQ[ch]=1; timeout counter starts at 0 on entry.
    - Exit on CH_DONE[ch], or on timeout expiry.
    - On exit: clear rem_mask[ch], RD_REQ deasserts on the next cycle.
    - If rem_mask is then non-zero, enter REQ for the next lowest channel, with at least one idle cycle between requests (RD_REQ low one cycle). Otherwise go to TRL.
  - TRL (1 cycle): EVT_END=1, then IDLE. A queued event may proceed IDLE->HDR on the next edge.
- Handshake rules:
  - CH_DONE on any channel other than the currently requested one is ignored.
  - CH_DONE is accepted in the first REQ cycle.
- Latency, idle and empty: L1A in cycle t gives EVT_START in t+2. For a non-empty mask, first RD_REQ in t+3.
- Empty-mask event: header/trailer only; EVT_START at t+2, EVT_END at t+3.
- CH_EN changes affect only subsequently queued events.

Optional Feature:
- Macro L1A_RDSCHED_TIMEOUT_EN.
- Defined:
  - A TMO_BITS counter runs in REQ.
  - At count 2^TMO_BITS-1 without CH_DONE, set EVT_TMO[ch] and release the request as if done.
- Undefined:
  - REQ waits indefinitely for CH_DONE.
  - EVT_TMO is constant 0 and the counter is not built.

Test Plan:
- Reset, then L1A with L1A_MATCH=6'b000101, CH_EN=6'h3F.
  - Required: EVT_START at t+2, EVT_NUM=0, RD_REQ=000001 from t+3.
  - CH_DONE[0] gives RD_REQ=0 for 1 cycle, then 000100.
  - CH_DONE[2] gives EVT_END the cycle after RD_REQ drops.
- L1A with MATCH=6'h3F, CH_EN=6'b000010: EVT_MASK=000010, and only RD_REQ[1] is ever asserted.
- 9 L1As with MATCH=0 in consecutive cycles, FSM stalled on a prior event awaiting CH_DONE.
  - Required: Q_FULL after the 8th, Q_OVF set on the 9th.
  - Later EVT_NUM sequence skips the dropped number; OVF_CLR clears Q_OVF.
- With L1A_RDSCHED_TIMEOUT_EN, TMO_BITS=4, MATCH=000011, no CH_DONE on channel 0.
  - Required: RD_REQ[0] released after 16 cycles, EVT_TMO=000001 at EVT_END, channel 1 still serviced.
- RST_N low mid-REQ: RD_REQ=0 asynchronously, BUSY=0, no EVT_END; the next L1A gets EVT_NUM=0.
- Full queue plus pop in the same cycle as L1A: no overflow, occupancy stays QDEPTH.

Source files
------------

// File: rtl/l1a_rdout_sched.sv
// rtl/l1a_rdout_sched.sv - L1A event descriptor queue and per-channel readout sequencer
// Optional per-channel done-timeout: define L1A_RDSCHED_TIMEOUT_EN
module l1a_rdout_sched #(
    parameter int NCH      = 6,
    parameter int QDEPTH   = 8,
    parameter int TMO_BITS = 10
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           L1A,
    input  logic [NCH-1:0] L1A_MATCH,
    input  logic [NCH-1:0] CH_EN,
    input  logic [NCH-1:0] CH_DONE,
    input  logic           OVF_CLR,
    output logic [NCH-1:0] RD_REQ,
    output logic           EVT_START,
    output logic           EVT_END,
    output logic [11:0]    EVT_NUM,
    output logic [NCH-1:0] EVT_MASK,
    output logic [NCH-1:0] EVT_TMO,
    output logic           Q_FULL,
    output logic           Q_OVF,
    output logic           BUSY
);
    localparam int AW = $clog2(QDEPTH);
    localparam int DW = 12 + NCH;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_REQ, S_TRL} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]  q_mem [QDEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    q_cnt;
    logic [11:0]    evt_cnt;
    logic           q_empty, push, pop, drop;

    logic [NCH-1:0] rem_mask, cur_ch;
    logic           gap, done_hit, tmo_hit, req_exit;

    assign q_empty = (q_cnt == '0);
    assign Q_FULL  = (q_cnt == (AW+1)'(QDEPTH));
    assign push    = L1A && (!Q_FULL || pop);
    assign drop    = L1A && Q_FULL && !pop;
    assign BUSY    = (state != S_IDLE) || !q_empty;

    // Serviced bits are cleared, so the lowest remaining bit is always the active channel
    assign cur_ch   = rem_mask & (~rem_mask + NCH'(1));
    assign done_hit = |(CH_DONE & cur_ch);
    assign RD_REQ   = (state == S_REQ && !gap) ? cur_ch : '0;

`ifdef L1A_RDSCHED_TIMEOUT_EN
    logic [TMO_BITS-1:0] tmo_cnt;

    assign tmo_hit = (state == S_REQ) && !gap && !done_hit && (tmo_cnt == '1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_cnt <= '0;
            EVT_TMO <= '0;
        end else begin
            if (state != S_REQ || gap) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + TMO_BITS'(1);
            if (pop)          EVT_TMO <= '0;
            else if (tmo_hit) EVT_TMO <= EVT_TMO | cur_ch;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign EVT_TMO = '0;
`endif

    always_ff @(posedge CLK) begin
        if (push) q_mem[wr_ptr] <= {evt_cnt, L1A_MATCH & CH_EN};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_cnt   <= '0;
            evt_cnt <= '0;
            Q_OVF   <= 1'b0;
        end else begin
            if (L1A)  evt_cnt <= evt_cnt + 12'd1;
            if (push) wr_ptr  <= wr_ptr + AW'(1);
            if (pop)  rd_ptr  <= rd_ptr + AW'(1);
            if (push && !pop)      q_cnt <= q_cnt + (AW+1)'(1);
            else if (pop && !push) q_cnt <= q_cnt - (AW+1)'(1);
            // a drop wins over a coincident clear
            if (drop)         Q_OVF <= 1'b1;
            else if (OVF_CLR) Q_OVF <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        req_exit  = 1'b0;
        EVT_START = 1'b0;
        EVT_END   = 1'b0;
        case (state)
            S_IDLE: begin
                if (!q_empty) begin
                    pop       = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                EVT_START = 1'b1;
                state_nxt = (rem_mask == '0) ? S_TRL : S_REQ;
            end
            S_REQ: begin
                // gap is the mandatory request-low cycle after each channel completes
                if (gap) begin
                    if (rem_mask == '0) state_nxt = S_TRL;
                end else begin
                    req_exit = done_hit || tmo_hit;
                end
            end
            S_TRL: begin
                EVT_END   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            EVT_NUM  <= '0;
            EVT_MASK <= '0;
            rem_mask <= '0;
            gap      <= 1'b0;
        end else begin
            if (pop) begin
                {EVT_NUM, EVT_MASK} <= q_mem[rd_ptr];
                rem_mask            <= q_mem[rd_ptr][NCH-1:0];
                gap                 <= 1'b0;
            end else if (req_exit) begin
                rem_mask <= rem_mask & ~cur_ch;
                gap      <= 1'b1;
            end else if (gap) begin
                gap <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_l1a_rdout_sched.sv
// tb/tb_l1a_rdout_sched.sv - directed and randomized bench for l1a_rdout_sched with event-level model
module tb_l1a_rdout_sched;
    localparam int NCH    = 6;
    localparam int QDEPTH = 8;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           L1A;
    logic [NCH-1:0] L1A_MATCH, CH_EN, CH_DONE;
    logic           OVF_CLR;
    logic [NCH-1:0] RD_REQ, EVT_MASK, EVT_TMO;
    logic           EVT_START, EVT_END, Q_FULL, Q_OVF, BUSY;
    logic [11:0]    EVT_NUM;

    l1a_rdout_sched #(.NCH(NCH), .QDEPTH(QDEPTH), .TMO_BITS(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .L1A(L1A), .L1A_MATCH(L1A_MATCH), .CH_EN(CH_EN),
        .CH_DONE(CH_DONE), .OVF_CLR(OVF_CLR), .RD_REQ(RD_REQ), .EVT_START(EVT_START),
        .EVT_END(EVT_END), .EVT_NUM(EVT_NUM), .EVT_MASK(EVT_MASK), .EVT_TMO(EVT_TMO),
        .Q_FULL(Q_FULL), .Q_OVF(Q_OVF), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int             errors = 0;
    int             checks = 0;
    logic [11:0]    l1a_cnt;
    logic [11:0]    exp_num_q[$];
    logic [NCH-1:0] exp_mask_q[$];
    logic [NCH-1:0] m_rem, m_prev_req;
    bit             m_done_sent;
    int             m_dly;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bench_l1a(input logic [NCH-1:0] match, input logic [NCH-1:0] en, input bit queued);
        L1A       = 1'b1;
        L1A_MATCH = match;
        CH_EN     = en;
        if (queued) begin
            exp_num_q.push_back(l1a_cnt);
            exp_mask_q.push_back(match & en);
        end
        l1a_cnt = l1a_cnt + 12'd1;
    endtask

    // Event-level model: events leave in order; channels are requested lowest first with a gap after each done
    task automatic mon_step();
        logic [NCH-1:0] lo, noise;
        if (EVT_START) begin
            chk("start_has_event", exp_num_q.size() != 0, 1);
            if (exp_num_q.size() != 0) begin
                chk("evt_num", EVT_NUM, exp_num_q[0]);
                chk("evt_mask", EVT_MASK, exp_mask_q[0]);
                m_rem = exp_mask_q[0];
            end
        end
        if (m_done_sent) begin
            chk("req_gap", RD_REQ, 0);
        end else if (RD_REQ != 0 && m_prev_req == 0) begin
            lo = m_rem & (~m_rem + NCH'(1));
            chk("req_order", RD_REQ, lo);
            m_rem = m_rem & ~lo;
            m_dly = $urandom_range(0, 3);
        end
        if (EVT_END) begin
            chk("end_all_serviced", m_rem, 0);
            chk("end_tmo", EVT_TMO, 0);
            if (exp_num_q.size() != 0) begin
                void'(exp_num_q.pop_front());
                void'(exp_mask_q.pop_front());
            end
        end
        m_prev_req  = RD_REQ;
        noise       = NCH'($urandom);
        CH_DONE     = noise & ~RD_REQ;
        m_done_sent = 1'b0;
        if (RD_REQ != 0) begin
            if (m_dly == 0) begin
                CH_DONE     = CH_DONE | RD_REQ;
                m_done_sent = 1'b1;
            end else begin
                m_dly--;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        m_prev_req  = '0;
        m_done_sent = 1'b0;
        while ((exp_num_q.size() != 0 || BUSY) && n < budget) begin
            mon_step();
            tick();
            n++;
        end
        CH_DONE = '0;
        chk("drain_empty", exp_num_q.size(), 0);
        chk("drain_idle", BUSY, 0);
    endtask

    initial begin
        int issued;
        int n;
        logic [11:0] stall_num;
        RST_N = 1'b0; L1A = 1'b0; L1A_MATCH = '0; CH_EN = '0; CH_DONE = '0; OVF_CLR = 1'b0;
        l1a_cnt = '0; m_rem = '0; m_prev_req = '0; m_done_sent = 1'b0; m_dly = 0;
        tick(); tick();
        chk("rst_rd_req", RD_REQ, 0);
        chk("rst_flags", {EVT_START, EVT_END, Q_FULL, Q_OVF, BUSY}, 0);
        chk("rst_evt_num", EVT_NUM, 0);
        RST_N = 1'b1;

        // basic two-channel event
        bench_l1a(6'b000101, 6'h3F, 0);
        tick(); L1A = 1'b0;
        chk("t1_no_early_start", EVT_START, 0);
        tick();
        chk("t1_start", EVT_START, 1);
        chk("t1_num", EVT_NUM, 0);
        chk("t1_mask", EVT_MASK, 6'b000101);
        chk("t1_no_req_in_hdr", RD_REQ, 0);
        tick();
        chk("t1_req0", RD_REQ, 6'b000001);
        tick();
        chk("t1_req0_held", RD_REQ, 6'b000001);
        CH_DONE = 6'b000001;
        tick(); CH_DONE = '0;
        chk("t1_gap", RD_REQ, 0);
        tick();
        chk("t1_req2", RD_REQ, 6'b000100);
        CH_DONE = 6'b000010;
        tick();
        chk("t1_wrong_done_ignored", RD_REQ, 6'b000100);
        CH_DONE = 6'b000100;
        tick(); CH_DONE = '0;
        chk("t1_req_drop", {RD_REQ, EVT_END}, 0);
        tick();
        chk("t1_end", EVT_END, 1);
        chk("t1_end_tmo", EVT_TMO, 0);
        tick();
        chk("t1_idle", {BUSY, EVT_END}, 0);

        // channel-enable masking, done accepted in first REQ cycle
        bench_l1a(6'h3F, 6'b000010, 0);
        tick(); L1A = 1'b0;
        tick();
        chk("t2_start", EVT_START, 1);
        chk("t2_num", EVT_NUM, 1);
        chk("t2_mask", EVT_MASK, 6'b000010);
        tick();
        chk("t2_req1", RD_REQ, 6'b000010);
        CH_DONE = 6'b000010;
        tick(); CH_DONE = '0;
        chk("t2_gap", RD_REQ, 0);
        tick();
        chk("t2_end", EVT_END, 1);
        tick();
        chk("t2_idle", BUSY, 0);

        // randomized traffic kept below queue capacity
        issued = 0;
        m_prev_req = '0; m_done_sent = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (issued >= 40 && exp_num_q.size() == 0 && !BUSY) break;
            mon_step();
            L1A = 1'b0;
            if (issued < 40 && exp_num_q.size() < QDEPTH - 1 && $urandom_range(0, 3) == 0) begin
                bench_l1a(NCH'($urandom), ($urandom_range(0, 2) == 0) ? 6'h3F : NCH'($urandom), 1);
                issued++;
            end
            tick();
        end
        L1A = 1'b0; CH_DONE = '0;
        chk("rand_all_ended", exp_num_q.size(), 0);
        chk("rand_no_ovf", Q_OVF, 0);

        // overflow while stalled, clear rules, then full queue with simultaneous pop
        stall_num = l1a_cnt;
        bench_l1a(6'b000001, 6'h3F, 0);
        tick(); L1A = 1'b0;
        tick(); tick();
        chk("t3_stall_req", RD_REQ, 6'b000001);
        for (int i = 0; i < 9; i++) begin
            bench_l1a(6'b000000, 6'h3F, i < 8);
            tick();
            if (i == 6) chk("t3_not_full_7", Q_FULL, 0);
            if (i == 7) begin
                chk("t3_full_8", Q_FULL, 1);
                chk("t3_no_ovf_8", Q_OVF, 0);
            end
        end
        chk("t3_ovf_9", Q_OVF, 1);
        bench_l1a(6'b000000, 6'h3F, 0);
        OVF_CLR = 1'b1;
        tick(); L1A = 1'b0;
        chk("t3_clr_with_drop", Q_OVF, 1);
        tick(); OVF_CLR = 1'b0;
        chk("t3_ovf_cleared", Q_OVF, 0);
        chk("t3_still_stalled", RD_REQ, 6'b000001);
        CH_DONE = 6'b000001;
        tick(); CH_DONE = '0;
        chk("t3_gap", RD_REQ, 0);
        tick();
        chk("t3_end", EVT_END, 1);
        chk("t3_end_num", EVT_NUM, stall_num);
        tick();
        chk("t3_full_at_pop", Q_FULL, 1);
        bench_l1a(6'b000000, 6'h3F, 1);
        tick(); L1A = 1'b0;
        chk("t3_push_pop_full", Q_FULL, 1);
        chk("t3_push_pop_no_ovf", Q_OVF, 0);
        drain(200);

`ifdef L1A_RDSCHED_TIMEOUT_EN
        bench_l1a(6'b000011, 6'h3F, 0);
        tick(); L1A = 1'b0;
        tick();
        chk("t5_start", EVT_START, 1);
        tick();
        chk("t5_req0", RD_REQ, 6'b000001);
        n = 0;
        while (RD_REQ == 6'b000001 && n < 40) begin
            n++;
            tick();
        end
        chk("t5_tmo_len", n, 16);
        chk("t5_gap", RD_REQ, 0);
        tick();
        chk("t5_req1", RD_REQ, 6'b000010);
        CH_DONE = 6'b000010;
        tick(); CH_DONE = '0;
        tick();
        chk("t5_end", EVT_END, 1);
        chk("t5_end_tmo", EVT_TMO, 6'b000001);
        tick();
`endif

        // asynchronous reset in the middle of a request
        bench_l1a(6'b000010, 6'h3F, 0);
        tick(); L1A = 1'b0;
        tick(); tick();
        chk("t4_req1", RD_REQ, 6'b000010);
        #2 RST_N = 1'b0;
        #1;
        chk("t4_async_req_drop", RD_REQ, 0);
        chk("t4_async_busy", BUSY, 0);
        chk("t4_async_num", EVT_NUM, 0);
        tick();
        chk("t4_no_end_in_rst", EVT_END, 0);
        RST_N = 1'b1;
        l1a_cnt = '0;
        exp_num_q.delete();
        exp_mask_q.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_quiet_after_rst", {EVT_END, EVT_START, BUSY}, 0);
        end
        bench_l1a(6'b000000, 6'h3F, 0);
        tick(); L1A = 1'b0;
        tick();
        chk("t4_start", EVT_START, 1);
        chk("t4_num_restart", EVT_NUM, 0);
        tick();
        chk("t4_empty_mask_end", EVT_END, 1);
        chk("t4_no_req", RD_REQ, 0);
        tick();
        chk("t4_idle", BUSY, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
